// File: rtl/fys_sched_pkg.sv
// Shared types and helpers for the Fisher-Yates shuffle scheduler.
//   state_e       : controller states
//   ERR_*         : bit indices into the sticky err vector
//   cw()          : clog2-based width helper, never returns less than 1
package fys_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_SHUFFLE = 3'd2,
    ST_READY   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam int unsigned ERR_TIMEOUT   = 0;
  localparam int unsigned ERR_ZERO_SEED = 1;

  // Width needed to hold values 0..n-1; at least one bit so vectors stay legal.
  function automatic int unsigned cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fys_perm_sched_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request vector
//   en         : arbitration enable; no grant and no pointer move when low
//   gnt        : one-hot grant, combinational from req, en and the pointer
module rr_arbiter
  import fys_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt
);

  localparam int unsigned PW = cw(N_REQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: first the requesters at or above the pointer, then wrap to 0.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (en && !found && req[i] && (PW'(i) >= ptr_q)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
        ptr_d  = (i == int'(N_REQ) - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (en && !found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
        ptr_d  = (i == int'(N_REQ) - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fys_perm_sched.sv
// Sequences one Fisher-Yates shuffle core and shares its read port.
//   clk, rst_n          : clock, async active-low reset
//   seed_in/valid/ready : seed handshake, ready only in IDLE
//   fys_start/fys_seed  : start pulse and held seed to the core
//   fys_done            : core completion level
//   fys_rd_en/addr/data : core read port (data has 1-cycle latency)
//   req/req_addr/gnt    : requester lookups, round-robin granted in READY
//   rsp_valid/rsp_data  : lookup response, one cycle after the grant
//   retire              : retire the current permutation early
//   perm_ready          : permutation available for reads
//   err                 : sticky {zero seed rejected, shuffle timeout}
module fys_perm_sched
  import fys_sched_pkg::*;
#(
  parameter int unsigned M           = 13,
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned REUSE_READS = 2 ** M,
  parameter int unsigned TIMEOUT     = 2 ** (M + 3)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        seed_in,
  input  logic               seed_valid,
  output logic               seed_ready,
  output logic               fys_start,
  output logic [63:0]        fys_seed,
  input  logic               fys_done,
  output logic               fys_rd_en,
  output logic [M-1:0]       fys_rd_addr,
  input  logic [M-1:0]       fys_data,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*M-1:0] req_addr,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [M-1:0]       rsp_data,
  input  logic               retire,
  output logic               perm_ready,
  output logic [1:0]         err
);

  localparam int unsigned CW = cw(REUSE_READS + 1);
  localparam int unsigned WW = cw(TIMEOUT);

  state_e           state_q, state_d;
  logic [63:0]      seed_q, seed_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic             any_gnt_c;
  logic [M-1:0]     rd_addr_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (state_q == ST_READY),
    .gnt   (gnt)
  );

  assign any_gnt_c = |gnt;

  // Read address of the granted requester; zero when nothing is granted.
  always_comb begin
    rd_addr_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) rd_addr_c = req_addr[i*M +: M];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    wdog_d      = wdog_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rsp_valid_d = gnt;
    case (state_q)
      ST_IDLE: begin
        if (seed_valid) begin
          // A zero seed would lock the xorshift generator in the core.
          if (seed_in != '0) begin
            seed_d  = seed_in;
            state_d = ST_START;
          end else begin
            err_d[ERR_ZERO_SEED] = 1'b1;
          end
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_SHUFFLE;
      end
      ST_SHUFFLE: begin
        wdog_d = wdog_q + WW'(1);
        // wdog_q == 0 marks the first cycle, where fys_done may be stale.
        if ((wdog_q != '0) && fys_done) begin
          state_d = ST_READY;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_IDLE;
        end
      end
      ST_READY: begin
        if (any_gnt_c) cnt_d = cnt_q + CW'(1);
        if ((any_gnt_c && (cnt_q == CW'(REUSE_READS - 1))) || retire) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last grant's response is delivered during this cycle.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      wdog_q      <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      wdog_q      <= wdog_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign seed_ready  = (state_q == ST_IDLE);
  assign fys_start   = (state_q == ST_START);
  assign perm_ready  = (state_q == ST_READY);
  assign fys_seed    = seed_q;
  assign err         = err_q;
  assign fys_rd_en   = any_gnt_c;
  assign fys_rd_addr = rd_addr_c;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = (rsp_valid_q != '0) ? fys_data : '0;

endmodule

// File: tb/tb_fys_perm_sched.sv
module tb_fys_perm_sched;

  logic        clk;
  logic        rst_n;
  logic [63:0] seed_in;
  logic        seed_valid;
  logic        seed_ready;
  logic        fys_start;
  logic [63:0] fys_seed;
  logic        fys_done;
  logic        fys_rd_en;
  logic [3:0]  fys_rd_addr;
  logic [3:0]  fys_data;
  logic [1:0]  req;
  logic [7:0]  req_addr;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [3:0]  rsp_data;
  logic        retire;
  logic        perm_ready;
  logic [1:0]  err;

  logic [63:0] t_seed_in;
  logic        t_seed_valid;
  logic        t_seed_ready;
  logic        t_fys_start;
  logic [63:0] t_fys_seed;
  logic        t_fys_done;
  logic        t_fys_rd_en;
  logic [3:0]  t_fys_rd_addr;
  logic [3:0]  t_fys_data;
  logic [1:0]  t_req;
  logic [7:0]  t_req_addr;
  logic [1:0]  t_gnt;
  logic [1:0]  t_rsp_valid;
  logic [3:0]  t_rsp_data;
  logic        t_retire;
  logic        t_perm_ready;
  logic [1:0]  t_err;

  typedef struct {
    int         cyc;
    logic [1:0] v;
    logic [3:0] d;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         mptr   = 0;
  logic [3:0] addrs [2];

  fys_perm_sched #(.M(4), .N_REQ(2), .REUSE_READS(4), .TIMEOUT(256)) dut (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .fys_start(fys_start), .fys_seed(fys_seed),
    .fys_done(fys_done), .fys_rd_en(fys_rd_en), .fys_rd_addr(fys_rd_addr),
    .fys_data(fys_data), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .retire(retire),
    .perm_ready(perm_ready), .err(err)
  );

  fys_perm_sched #(.M(4), .N_REQ(2), .REUSE_READS(4), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .seed_in(t_seed_in), .seed_valid(t_seed_valid),
    .seed_ready(t_seed_ready), .fys_start(t_fys_start), .fys_seed(t_fys_seed),
    .fys_done(t_fys_done), .fys_rd_en(t_fys_rd_en), .fys_rd_addr(t_fys_rd_addr),
    .fys_data(t_fys_data), .req(t_req), .req_addr(t_req_addr), .gnt(t_gnt),
    .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .retire(t_retire),
    .perm_ready(t_perm_ready), .err(t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: a fixed permutation, read with one cycle of latency.
  function automatic logic [3:0] pval(input logic [3:0] a);
    return 4'((32'(a) * 7 + 3) % 16);
  endfunction

  always @(posedge clk) begin
    if (fys_rd_en) fys_data <= pval(fys_rd_addr);
  end

  // Reference round-robin choice: first asserted index starting at p.
  function automatic int pick(input logic [1:0] r, input int p);
    for (int k = 0; k < 2; k++) begin
      if (r[(p + k) % 2]) return (p + k) % 2;
    end
    return -1;
  endfunction

  // Response monitor: compare against the scoreboard entry due this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== e.v || rsp_data !== e.d) begin
        errors++;
        $display("FAIL rsp: got valid=%b data=%h, want valid=%b data=%h",
                 rsp_valid, rsp_data, e.v, e.d);
      end
    end else if (rsp_valid !== 2'b00) begin
      checks++;
      errors++;
      $display("FAIL rsp_unexpected: got valid=%b, want 00", rsp_valid);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic load_seed(input logic [63:0] s);
    @(negedge clk);
    seed_in    = s;
    seed_valid = 1'b1;
    #1;
    checks++;
    if (seed_ready !== 1'b1) begin
      errors++;
      $display("FAIL seed_ready: got %b, want 1", seed_ready);
    end
    @(negedge clk);
    seed_valid = 1'b0;
    #1;
    checks++;
    if (fys_start !== 1'b1 || fys_seed !== s || seed_ready !== 1'b0) begin
      errors++;
      $display("FAIL start: got start=%b seed=%h rdy=%b, want 1 %h 0",
               fys_start, fys_seed, seed_ready, s);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fys_start !== 1'b0 || perm_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: got start=%b pr=%b, want 0 0", fys_start, perm_ready);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({seed_ready, fys_start, fys_rd_en, gnt, rsp_valid, perm_ready, err} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 1000000000",
               {seed_ready, fys_start, fys_rd_en, gnt, rsp_valid, perm_ready, err});
    end
    checks++;
    if (fys_seed !== 64'd0 || fys_rd_addr !== 4'd0 || rsp_data !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: got seed=%h addr=%h data=%h, want 0 0 0",
               fys_seed, fys_rd_addr, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (seed_ready !== 1'b1 || fys_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b start=%b, want 1 0", seed_ready, fys_start);
    end
  endtask

  task automatic test_basic;
    fys_done = 1'b0;
    load_seed(64'h1);
    repeat (99) @(negedge clk);
    #1;
    checks++;
    if (perm_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got perm_ready=%b, want 0", perm_ready);
    end
    fys_done = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (perm_ready !== 1'b1 || seed_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready: got pr=%b rdy=%b, want 1 0", perm_ready, seed_ready);
    end
  endtask

  task automatic test_round_robin;
    int         w;
    logic [1:0] exp_g;
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) @(negedge clk);
      #1;
      w     = pick(req, mptr);
      exp_g = 2'(1 << w);
      checks++;
      if (gnt !== exp_g || fys_rd_en !== 1'b1 || fys_rd_addr !== addrs[w]) begin
        errors++;
        $display("FAIL rr_grant%0d: got gnt=%b en=%b addr=%h, want %b 1 %h",
                 g, gnt, fys_rd_en, fys_rd_addr, exp_g, addrs[w]);
      end
      sb.push_back('{cyc + 1, exp_g, pval(addrs[w])});
      mptr = (w + 1) % 2;
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 2'b00 || fys_rd_en !== 1'b0 || perm_ready !== 1'b0 || seed_ready !== 1'b0) begin
      errors++;
      $display("FAIL reuse_drain: got gnt=%b en=%b pr=%b rdy=%b, want 00 0 0 0",
               gnt, fys_rd_en, perm_ready, seed_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (seed_ready !== 1'b1 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL reuse_idle: got rdy=%b gnt=%b, want 1 00", seed_ready, gnt);
    end
    req = 2'b00;
  endtask

  task automatic test_stale_done;
    load_seed(64'h2);
    @(negedge clk);
    #1;
    checks++;
    if (perm_ready !== 1'b0) begin
      errors++;
      $display("FAIL stale_first: got perm_ready=%b, want 0", perm_ready);
    end
    fys_done = 1'b0;
    req      = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (perm_ready !== 1'b0 || gnt !== 2'b00) begin
        errors++;
        $display("FAIL stale_hold%0d: got pr=%b gnt=%b, want 0 00", k, perm_ready, gnt);
      end
    end
    req      = 2'b00;
    fys_done = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (perm_ready !== 1'b1 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL stale_ready: got pr=%b gnt=%b, want 1 00", perm_ready, gnt);
    end
  endtask

  task automatic test_retire;
    int         w;
    logic [1:0] exp_g;
    req    = 2'b01;
    retire = 1'b1;
    #1;
    w     = pick(req, mptr);
    exp_g = 2'(1 << w);
    checks++;
    if (gnt !== exp_g || fys_rd_addr !== addrs[w]) begin
      errors++;
      $display("FAIL retire_grant: got gnt=%b addr=%h, want %b %h", gnt, fys_rd_addr, exp_g, addrs[w]);
    end
    sb.push_back('{cyc + 1, exp_g, pval(addrs[w])});
    mptr = (w + 1) % 2;
    @(negedge clk);
    retire = 1'b0;
    req    = 2'b00;
    #1;
    checks++;
    if (perm_ready !== 1'b0 || seed_ready !== 1'b0) begin
      errors++;
      $display("FAIL retire_drain: got pr=%b rdy=%b, want 0 0", perm_ready, seed_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (seed_ready !== 1'b1) begin
      errors++;
      $display("FAIL retire_idle: got rdy=%b, want 1", seed_ready);
    end
  endtask

  task automatic test_zero_seed;
    @(negedge clk);
    seed_in    = 64'd0;
    seed_valid = 1'b1;
    #1;
    checks++;
    if (seed_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_rdy: got %b, want 1", seed_ready);
    end
    @(negedge clk);
    seed_valid = 1'b0;
    #1;
    checks++;
    if (err !== 2'b10 || seed_ready !== 1'b1 || fys_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_seed: got err=%b rdy=%b start=%b, want 10 1 0", err, seed_ready, fys_start);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fys_start !== 1'b0 || seed_ready !== 1'b1 || err !== 2'b10) begin
      errors++;
      $display("FAIL zero_stay: got start=%b rdy=%b err=%b, want 0 1 10", fys_start, seed_ready, err);
    end
  endtask

  task automatic test_async_reset;
    int         w;
    logic [1:0] exp_g;
    load_seed(64'h3);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (perm_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_ready: got perm_ready=%b, want 1", perm_ready);
    end
    req = 2'b11;
    #1;
    w     = pick(req, mptr);
    exp_g = 2'(1 << w);
    checks++;
    if (gnt !== exp_g) begin
      errors++;
      $display("FAIL ar_grant: got gnt=%b, want %b", gnt, exp_g);
    end
    rst_n = 1'b0;
    #1;
    mptr = 0;
    checks++;
    if ({gnt, fys_rd_en, rsp_valid, perm_ready, err, fys_start, seed_ready} !== 10'b00_0_00_0_00_0_1
        || fys_seed !== 64'd0 || fys_rd_addr !== 4'd0) begin
      errors++;
      $display("FAIL ar_outputs: got gnt=%b en=%b rv=%b pr=%b err=%b st=%b rdy=%b seed=%h",
               gnt, fys_rd_en, rsp_valid, perm_ready, err, fys_start, seed_ready, fys_seed);
    end
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || seed_ready !== 1'b1) begin
        errors++;
        $display("FAIL ar_after%0d: got rv=%b rdy=%b, want 00 1", k, rsp_valid, seed_ready);
      end
    end
  endtask

  task automatic test_timeout;
    @(negedge clk);
    t_seed_in    = 64'h5;
    t_seed_valid = 1'b1;
    @(negedge clk);
    t_seed_valid = 1'b0;
    #1;
    checks++;
    if (t_fys_start !== 1'b1) begin
      errors++;
      $display("FAIL to_start: got %b, want 1", t_fys_start);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (t_seed_ready !== 1'b0 || t_err !== 2'b00) begin
        errors++;
        $display("FAIL to_shuffle%0d: got rdy=%b err=%b, want 0 00", k, t_seed_ready, t_err);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (t_err !== 2'b01 || t_seed_ready !== 1'b1 || t_perm_ready !== 1'b0) begin
      errors++;
      $display("FAIL to_err: got err=%b rdy=%b pr=%b, want 01 1 0", t_err, t_seed_ready, t_perm_ready);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    seed_in      = '0;
    seed_valid   = 1'b0;
    fys_done     = 1'b0;
    req          = 2'b00;
    req_addr     = {4'd9, 4'd5};
    retire       = 1'b0;
    addrs[0]     = 4'd5;
    addrs[1]     = 4'd9;
    t_seed_in    = '0;
    t_seed_valid = 1'b0;
    t_fys_done   = 1'b0;
    t_fys_data   = '0;
    t_req        = 2'b00;
    t_req_addr   = '0;
    t_retire     = 1'b0;

    test_reset;
    test_basic;
    test_round_robin;
    test_stale_done;
    test_retire;
    test_zero_seed;
    test_async_reset;
    test_timeout;

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending responses, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fys_perm_sched.md
# fys_perm_sched

Controller that sequences one Fisher-Yates shuffle core and shares its read port. It takes a 64-bit seed over a valid/ready handshake and pulses the core's start. It waits for shuffle completion, then round-robin arbitrates permutation lookups from N_REQ requesters. Once the permutation has been read REUSE_READS times, or on explicit request, it retires the permutation and returns to seed acceptance. It sits between the shuffle core and the masking/shuffling consumers that need random index permutations.

## Interface
- M, 13: permutation index width; permutation length 2^M.
- N_REQ, 2: number of read requesters (≥1).
- REUSE_READS, 2^M: reads served before forced retire (≥1).
- TIMEOUT, 2^(M+3): max SHUFFLE cycles before timeout error.

Ports:
- clk  in  1  clock; only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- seed_in  in  64  seed for the next shuffle.
- seed_valid  in  1  seed offered.
- seed_ready  out  1  high in IDLE only.
- fys_start  out  1  one-cycle start pulse to the core.
- fys_seed  out  64  registered seed; held stable from START until the next accepted seed.
- fys_done  in  1  core completion level.
- fys_rd_en  out  1  core read-port override.
- fys_rd_addr  out  M  core read address.
- fys_data  in  M  core read data; 1-cycle registered latency.
- req  in  N_REQ  per-requester lookup request.
- req_addr  in  N_REQ*M  packed addresses; requester i uses bits [i*M +: M].
- gnt  out  N_REQ  one-hot grant, combinational from req and state.
- rsp_valid  out  N_REQ  one-hot; high 1 cycle after the grant.
- rsp_data  out  M  permutation value for rsp_valid.
- retire  in  1  request to retire the current permutation.
- perm_ready  out  1  high in READY.
- err  out  2  sticky flags; bit0 = shuffle timeout, bit1 = zero seed rejected.

## Operation
- States: IDLE, START, SHUFFLE, READY, DRAIN.
- IDLE: seed_ready=1.
  - A handshake with a nonzero seed loads fys_seed and moves to START.
  - A handshake with a zero seed completes but is discarded: err[1] is set, and the state stays IDLE. A zero seed locks the xorshift generator.
- START: fys_start=1 for exactly one cycle, then SHUFFLE. Clear the watchdog.
- SHUFFLE: fys_rd_en=0 (a read would corrupt shuffle addressing).
  - fys_done is ignored in the first SHUFFLE cycle. From the second cycle on, fys_done=1 moves to READY.
  - If the watchdog reaches TIMEOUT-1 first: set err[0] and return to IDLE.
- READY: perm_ready=1.
  - A round-robin arbiter picks one asserted req per cycle. Priority pointer = index after the last granted requester; reset pointer = 0.
  - Per grant: fys_rd_en=1, fys_rd_addr=req_addr of the winner. A requester holds req until granted.
  - Read counter (width clog2(REUSE_READS+1)) increments per grant.
  - The grant that makes count == REUSE_READS moves to DRAIN. So does retire=1 (sampled that cycle). The grant issued in that same cycle is still honoured.
- DRAIN: gnt=0, fys_rd_en=0. Deliver any outstanding response, then go to IDLE. Clear the read counter.
- Response: rsp_valid[w] and rsp_data=fys_data one cycle after the grant to w. rsp_valid=0 otherwise.
- Outside READY: gnt=0, fys_rd_en=0, fys_rd_addr=0.

## Timing
- Reset values: state IDLE, seed_ready=1, fys_start=0, fys_seed=0, fys_rd_en=0, fys_rd_addr=0, gnt=0, rsp_valid=0, rsp_data=0, perm_ready=0, err=0, RR pointer 0.
- err bits clear only on rst_n.
- Seed accept → fys_start high on the next cycle. Seed acceptance to first possible grant ≥ 3 cycles plus core shuffle time.
- Grant throughput: 1 per cycle. Latency grant→rsp_valid is exactly 1 cycle.
- Reset asserted mid-operation: immediate return to reset values.
  - The core is not re-initialised by this block; the next START restarts it.
  - Pending responses are dropped.
- fys_done already high on entry to SHUFFLE (stale from the previous run) must not cause early READY. The first-cycle ignore covers this.

## Structure
- Package fys_sched_pkg holds:
  - the state enum;
  - ERR_TIMEOUT=0 and ERR_ZERO_SEED=1 bit indices;
  - the clog2-based width helper.
- Sub-module rr_arbiter: parameter N_REQ; inputs req and an enable; outputs a one-hot gnt; contains the rotating pointer. Reusable by other shared-port blocks.

## Test plan
- Basic flow: seed 0x1 accepted. fys_start high 1 cycle. Model core asserts fys_done after 100 cycles → perm_ready=1 on the following cycle.
- Stale done: hold fys_done=1 through START. SHUFFLE stays until fys_done drops and re-rises; no grant issued early.
- Round-robin: req=2'b11 continuously with addrs 5 and 9.
  - Grants alternate 01,10,01,…
  - rsp_valid follows each grant by 1 cycle with rsp_data = core value at 5 or 9.
- Retire with REUSE_READS=4: after the 4th grant, DRAIN then IDLE; seed_ready=1. A 5th req is not granted.
- Errors:
  - Zero seed → err=2'b10, state stays IDLE, no fys_start.
  - With TIMEOUT=16 and fys_done never asserted → err[0]=1 and IDLE after 16 SHUFFLE cycles.
- Async reset during READY with a grant pending → all outputs 0 immediately. No rsp_valid after release.
